// File: rtl/ysyx_23060072_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, keeps one IMEM request in flight,
// and buffers returned words in a 2-entry queue that feeds IF/ID.
module ysyx_23060072_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_pc_i,
  input  logic        stall_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        flush_o
);

  typedef enum logic {S_REQ = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        drop, drop_nxt;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic [31:0] q_inst [2];
  logic [31:0] q_pc   [2];
  logic [1:0]  count;
  logic        redirect;
  logic        hs;
  logic        push;
  logic        pop;
  logic        push_slot;

  // Redirect targets are word aligned by clearing the low bits; misalignment is not trapped.
  function automatic logic [31:0] align_target(input logic [31:0] t);
    return t & 32'hFFFF_FFFC;
  endfunction

  assign redirect  = ex_valid_i & jump_flag_i;
  assign hs        = imem_req_valid_o & imem_req_ready_i;
  assign push      = (state == S_WAIT) & imem_rsp_valid_i & ~drop & ~redirect;
  assign pop       = inst_valid_o & ~stall_i & ~redirect;
  assign push_slot = pop ? (count == 2'd2) : (count == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
    end
  end

  // A redirect that leaves a response outstanding marks it stale; a response that
  // lands in the redirect cycle itself is simply ignored.
  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    case (state)
      S_REQ: begin
        if (hs) begin
          state_nxt = S_WAIT;
          if (redirect) drop_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          state_nxt = S_REQ;
          drop_nxt  = 1'b0;
        end else if (redirect) begin
          drop_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = S_REQ;
        drop_nxt  = 1'b0;
      end
    endcase
  end

  always_comb begin
    imem_req_valid_o = ~rst & (state == S_REQ) & (count != 2'd2);
    flush_o          = ~rst & redirect;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      count <= 2'd0;
    end else begin
      if (redirect)  pc <= align_target(jump_pc_i);
      else if (hs)   pc <= pc + 32'd4;
      if (redirect) begin
        count <= 2'd0;
      end else begin
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage shifts toward entry 0 on pop; a same-cycle push lands after the shift.
  always_ff @(posedge clk) begin
    if (hs) req_pc <= pc;
    if (pop) begin
      q_inst[0] <= q_inst[1];
      q_pc[0]   <= q_pc[1];
    end
    if (push) begin
      q_inst[push_slot] <= imem_rsp_data_i;
      q_pc[push_slot]   <= req_pc;
    end
  end

  assign imem_req_addr_o = pc;
  assign inst_valid_o    = (count != 2'd0);
  assign inst_o          = inst_valid_o ? q_inst[0] : 32'd0;
  assign inst_pc_o       = inst_valid_o ? q_pc[0]   : 32'd0;

endmodule

// File: doc/ysyx_23060072_fetch_ctrl.md
# ysyx_23060072_fetch_ctrl

Instruction-fetch controller at the front of the RV32E pipeline. It owns the architectural fetch PC and issues one-outstanding fetch requests to instruction memory. It buffers returned instructions in a 2-entry queue that feeds the IF/ID register. It consumes the branch/jump resolution (`jump_flag`/`jump_pc`) produced in EX: on a taken redirect it retargets the PC, flushes younger stages, and discards any stale in-flight response.

## Interface
- `RESET_PC`, default 32'h8000_0000: first fetch address after reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `ex_valid_i`  in  1  EX stage holds a valid instruction; qualifies `jump_flag_i`.
- `jump_flag_i`  in  1  taken branch/JAL/JALR/FENCE.I from EX ALU.
- `jump_pc_i`  in  32  redirect target from EX ALU.
- `stall_i`  in  1  decode cannot accept an instruction this cycle.
- `imem_req_valid_o`  out  1  fetch request valid.
- `imem_req_ready_i`  in  1  IMEM accepts request.
- `imem_req_addr_o`  out  32  fetch address.
- `imem_rsp_valid_i`  in  1  fetch data valid; no back-pressure, must be accepted.
- `imem_rsp_data_i`  in  32  fetched instruction word.
- `inst_valid_o`  out  1  queue head valid.
- `inst_o`  out  32  queue head instruction.
- `inst_pc_o`  out  32  PC of queue head.
- `flush_o`  out  1  kill IF/ID and ID/EX contents this cycle.

## Operation
- `redirect = ex_valid_i & jump_flag_i`. Effective target is `{jump_pc_i[31:2],2'b00}`; low bits are forced to zero and no exception is raised.
- Registers:
  - `pc`: next request address.
  - `req_pc`: address in flight.
  - `state ∈ {REQ, WAIT}`.
  - `drop`: discard next response.
  - Queue: 2 entries of {inst, pc}, with `count` 0..2.
- REQ:
  - `imem_req_valid_o = (count < 2)`. Addr = `pc`.
  - On handshake (valid & ready): `req_pc <= pc`, `pc <= pc + 4` (mod 2^32), go to WAIT.
- WAIT:
  - `imem_req_valid_o = 0`.
  - On `imem_rsp_valid_i`: if `drop`, discard the response and clear `drop`. Otherwise push {data, `req_pc`}. In both cases go to REQ.
- Issue rule: at most one request outstanding. A request issues only when `count < 2`, so every non-dropped response has a free slot, counting a pop in the same cycle.
- Pop: `inst_valid_o & ~stall_i`. Push and pop in the same cycle leaves `count` unchanged.
- Redirect, highest priority:
  - `flush_o = redirect`, combinational in the same cycle.
  - Queue is cleared and any pop/push that cycle is ignored.
  - `pc <= target`.
  - If the state is WAIT with no response this cycle, or a request handshakes this cycle: set `drop=1` and stay in or enter WAIT.
  - If a response arrives this cycle: discard it, `drop` stays 0, go to REQ.
  - A redirect while `drop` is already 1 keeps `drop=1`.
  - A request valid with the old `pc` in the redirect cycle is permitted; if accepted, its response is dropped.
- Reset: `pc=RESET_PC`, `state=REQ`, `drop=0`, `count=0`.

## Timing
- Reset values: `imem_req_valid_o=0` while `rst` is high; `inst_valid_o=0`; `flush_o=0`; `imem_req_addr_o=RESET_PC`; `inst_o=0`; `inst_pc_o=0`.
- First request is valid in the first cycle after `rst` deasserts.
- Fetch latency: handshake at cycle N, response at N+k (k≥1), `inst_valid_o` at N+k+1 (queue output is registered).
- Steady-state throughput with k=1: 1 instruction per 2 cycles.
- Redirect in cycle N: `flush_o` is high in N. `imem_req_addr_o = target` from N+1 (in REQ, with no response pending to drop). `inst_valid_o` is low from N+1 until the target's response has been pushed.
- Reset asserted mid-fetch: the outstanding response arriving after reset is not tracked. The IMEM is reset on the same `rst`, so no response may arrive after reset.

## Test plan
- Reset, `RESET_PC`=0x8000_0000, always-ready 1-cycle IMEM, no stall:
  - Requests go to 0x80000000, 0x80000004, 0x80000008.
  - `inst_pc_o` shows each PC, one instruction every 2 cycles, data matching.
- Hold `stall_i=1` for 10 cycles:
  - `count` reaches 2 and `imem_req_valid_o` drops to 0.
  - On release, both entries drain in order with no loss or duplicate.
- Redirect while in WAIT (request to 0x80000008 in flight), `jump_pc_i=0x80000100`:
  - `flush_o` pulses for 1 cycle.
  - The 0x80000008 response is discarded.
  - Next request is 0x80000100 and the next `inst_pc_o` is 0x80000100.
- Redirect in the same cycle as the response arrives:
  - Response is discarded and `drop` stays 0.
  - Next cycle the request goes to the target.
- Redirect in the same cycle as a request handshake:
  - `drop` is set and that response is discarded.
  - The following request is to the target.
- `jump_pc_i=0x80000203` with `ex_valid_i=1`: next fetch address is 0x80000200. `jump_flag_i=1` with `ex_valid_i=0`: no flush, fetch continues sequentially.
